// File: rtl/ring_buffer_replay_pkg.sv
// Shared constants and pointer helpers for the replayable ring buffer.
package ring_buffer_pkg;
  localparam int DEF_DATA_WIDTH  = 4;
  localparam int DEF_DATA_OF_SET = 4;
  localparam int DEF_BUFFER_SIZE = 4;

  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned size);
    return (ptr >= size - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/ring_buffer_replay_if.sv
// Producer/consumer handshake, replay controls and occupancy status of the ring buffer.
interface ring_buffer_replay_if import ring_buffer_pkg::*; #(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DATA_OF_SET = DEF_DATA_OF_SET,
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE
);
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  logic                                   in_valid;
  logic                                   in_ready;
  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] din;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] dout;
  logic                                   mark;
  logic                                   rewind;
  // 'release' is a reserved word, hence the longer name
  logic                                   release_mark;
  logic [CW-1:0]                          used;
  logic [CW-1:0]                          readable;
  logic                                   almost_full;
  logic                                   almost_empty;

  modport master (
    output in_valid, din, out_ready, mark, rewind, release_mark,
    input  in_ready, out_valid, dout, used, readable, almost_full, almost_empty
  );
  modport slave (
    input  in_valid, din, out_ready, mark, rewind, release_mark,
    output in_ready, out_valid, dout, used, readable, almost_full, almost_empty
  );
endinterface

// File: rtl/ring_buffer_replay_wrap_ptr.sv
// Modulo-SIZE pointer; load beats inc so a rewind wins over a same-cycle pop.
module rb_wrap_ptr import ring_buffer_pkg::*; #(
  parameter int SIZE = DEF_BUFFER_SIZE,
  parameter int PW   = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  output logic [PW-1:0] ptr
);
  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load)     ptr_d = load_val;
    else if (inc) ptr_d = PW'(wrap_inc(32'(ptr_q), SIZE));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;

  assign ptr = ptr_q;
endmodule

// File: rtl/ring_buffer_replay.sv
// Multi-lane FWFT ring buffer with mark/rewind replay of a retained window.
module ring_buffer_replay import ring_buffer_pkg::*; #(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DATA_OF_SET = DEF_DATA_OF_SET,
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
  parameter int AF_LEVEL    = 3,
  parameter int AE_LEVEL    = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  ring_buffer_replay_if.slave   bus
);
  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  typedef logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] entry_t;

  entry_t        mem_q [BUFFER_SIZE];
  logic [PW-1:0] wptr, rptr, mptr_q, mptr_d;
  logic          mark_active_q, mark_active_d;
  logic [CW-1:0] used_q, used_d, readable_q, readable_d;
  logic          full, push, pop, rew_act, rel_act, mark_act;

  // Priority resolves on the raw pulses: any rewind masks release and mark
  always_comb begin
    full     = (used_q == CW'(BUFFER_SIZE));
    push     = bus.in_valid && !full;
    pop      = (readable_q != '0) && bus.out_ready && !bus.rewind;
    rew_act  = bus.rewind && mark_active_q;
    rel_act  = bus.release_mark && !bus.rewind;
    mark_act = bus.mark && !bus.rewind && !bus.release_mark;
  end

  always_comb begin
    mptr_d        = mptr_q;
    mark_active_d = mark_active_q;
    readable_d    = readable_q + CW'(push) - CW'(pop);
    // While marked, popped entries stay retained until release or re-mark
    used_d        = used_q + CW'(push) - CW'(pop && !mark_active_q);
    if (rew_act) begin
      readable_d = used_q + CW'(push);
    end else if (rel_act) begin
      mark_active_d = 1'b0;
      used_d        = readable_d;
    end else if (mark_act) begin
      mptr_d        = rptr;
      mark_active_d = 1'b1;
      used_d        = readable_q + CW'(push);
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mptr_q        <= '0;
      mark_active_q <= 1'b0;
      used_q        <= '0;
      readable_q    <= '0;
    end else begin
      mptr_q        <= mptr_d;
      mark_active_q <= mark_active_d;
      used_q        <= used_d;
      readable_q    <= readable_d;
    end

  always_ff @(posedge clk)
    if (push) mem_q[wptr] <= bus.din;

  rb_wrap_ptr #(.SIZE(BUFFER_SIZE), .PW(PW)) u_wptr (
    .clk(clk), .rst_n(rst_n), .inc(push), .load(1'b0), .load_val('0), .ptr(wptr)
  );
  rb_wrap_ptr #(.SIZE(BUFFER_SIZE), .PW(PW)) u_rptr (
    .clk(clk), .rst_n(rst_n), .inc(pop), .load(rew_act), .load_val(mptr_q), .ptr(rptr)
  );

  assign bus.in_ready     = !full;
  assign bus.out_valid    = (readable_q != '0);
  assign bus.dout         = (readable_q != '0) ? mem_q[rptr] : '0;
  assign bus.used         = used_q;
  assign bus.readable     = readable_q;
  assign bus.almost_full  = (used_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (readable_q <= CW'(AE_LEVEL));
endmodule

// File: tb/tb_ring_buffer_replay.sv
// Scoreboard bench: a queue-based model predicts per-cycle outputs, a negedge monitor compares.
module tb_ring_buffer_replay;
  localparam int BS = 5, AF = 4, AE = 1, DW = 4, DS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ring_buffer_replay_if #(.DATA_WIDTH(DW), .DATA_OF_SET(DS), .BUFFER_SIZE(BS)) bus ();

  ring_buffer_replay #(.DATA_WIDTH(DW), .DATA_OF_SET(DS), .BUFFER_SIZE(BS),
                       .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [15:0] dout;
    int          used;
    int          readable;
    bit          in_ready;
    bit          out_valid;
    bit          af;
    bit          ae;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] store[$];   // retained + readable entries, oldest first
  int          rd_off;     // entries of store already popped since mark/rewind
  bit          mact;
  int          vecs, errs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.used      = store.size();
    e.readable  = store.size() - rd_off;
    e.in_ready  = (e.used != BS);
    e.out_valid = (e.readable != 0);
    e.dout      = e.out_valid ? store[rd_off] : 16'h0;
    e.af        = (e.used >= AF);
    e.ae        = (e.readable <= AE);
    return e;
  endfunction

  task automatic model_step(input bit iv, input logic [15:0] d, input bit ordy,
                            input bit mk, input bit rw, input bit rl);
    bit push, pop;
    int n;
    push = iv && (store.size() != BS);
    pop  = ((store.size() - rd_off) > 0) && ordy && !rw;
    if (rw) begin
      if (mact) rd_off = 0;
    end else if (rl) begin
      if (pop) begin
        if (mact) rd_off++;
        else void'(store.pop_front());
      end
      n = rd_off;
      repeat (n) void'(store.pop_front());
      rd_off = 0;
      mact   = 0;
    end else if (mk) begin
      n = rd_off;
      repeat (n) void'(store.pop_front());
      rd_off = pop ? 1 : 0;
      mact   = 1;
    end else if (pop) begin
      if (mact) rd_off++;
      else void'(store.pop_front());
    end
    if (push) store.push_back(d);
  endtask

  task automatic cyc(input bit iv, input logic [15:0] d, input bit ordy,
                     input bit mk, input bit rw, input bit rl);
    @(posedge clk); #1;
    exp_q.push_back(model_out());
    bus.in_valid = iv; bus.din = d; bus.out_ready = ordy;
    bus.mark = mk; bus.rewind = rw; bus.release_mark = rl;
    model_step(iv, d, ordy, mk, rw, rl);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.din = '0; bus.out_ready = 0;
    bus.mark = 0; bus.rewind = 0; bus.release_mark = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".in_ready"},     32'(bus.in_ready), 1);
    chk({tag, ".out_valid"},    32'(bus.out_valid), 0);
    chk({tag, ".dout"},         32'(bus.dout), 0);
    chk({tag, ".used"},         32'(bus.used), 0);
    chk({tag, ".readable"},     32'(bus.readable), 0);
    chk({tag, ".almost_full"},  32'(bus.almost_full), 0);
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dout",         32'(bus.dout), 32'(e.dout));
      chk("used",         32'(bus.used), e.used);
      chk("readable",     32'(bus.readable), e.readable);
      chk("in_ready",     32'(bus.in_ready), 32'(e.in_ready));
      chk("out_valid",    32'(bus.out_valid), 32'(e.out_valid));
      chk("almost_full",  32'(bus.almost_full), 32'(e.af));
      chk("almost_empty", 32'(bus.almost_empty), 32'(e.ae));
    end
  end

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom()), 1'($urandom_range(0, 2) != 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
  endtask

  initial begin
    logic [15:0] a, b, c;
    vecs = 0; errs = 0; rd_off = 0; mact = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_reset("reset");

    // Fill to full, attempt an overflow push, then drain
    for (int k = 1; k <= 5; k++) cyc(1, {4{4'(k)}}, 0, 0, 0, 0);
    cyc(1, 16'h6666, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 16'h0, 1, 0, 0, 0);

    // Streaming at partial then full occupancy
    for (int k = 0; k < 3; k++) cyc(1, 16'($urandom()), 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(1, 16'($urandom()), 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) cyc(1, 16'($urandom()), 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(1, 16'($urandom()), 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 16'h0, 1, 0, 0, 0);

    // Replay: push A,B,C; mark; pop two; rewind; pop all three again
    a = 16'($urandom()); b = 16'($urandom()); c = 16'($urandom());
    cyc(1, a, 0, 0, 0, 0); cyc(1, b, 0, 0, 0, 0); cyc(1, c, 0, 0, 0, 0);
    cyc(0, 16'h0, 0, 1, 0, 0);
    cyc(0, 16'h0, 1, 0, 0, 0); cyc(0, 16'h0, 1, 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 16'h0, 1, 0, 0, 0);

    // Release frees the window; a following rewind is ignored
    cyc(0, 16'h0, 0, 0, 0, 1);
    cyc(0, 16'h0, 1, 0, 1, 0);
    cyc(0, 16'h0, 0, 0, 0, 0);

    // Collisions: rewind+mark+pop, then push together with rewind at used=4
    cyc(1, 16'($urandom()), 0, 0, 0, 0); cyc(1, 16'($urandom()), 0, 0, 0, 0);
    cyc(0, 16'h0, 0, 1, 0, 0);
    cyc(0, 16'h0, 1, 0, 0, 0);
    cyc(0, 16'h0, 1, 1, 1, 0);
    cyc(0, 16'h0, 1, 0, 0, 0);
    cyc(1, 16'($urandom()), 0, 0, 0, 0); cyc(1, 16'($urandom()), 0, 0, 0, 0);
    cyc(1, 16'($urandom()), 0, 0, 1, 0);
    cyc(1, 16'($urandom()), 1, 0, 0, 1);
    for (int k = 0; k < 6; k++) cyc(0, 16'h0, 1, 0, 0, 0);

    // Random traffic, asynchronous reset mid-stream, then more traffic
    rand_cycles(150);
    @(posedge clk); #3;
    exp_q.delete();
    idle_inputs();
    rst_n = 1'b0;
    #1 chk_reset("async_reset");
    store.delete(); rd_off = 0; mact = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rand_cycles(120);
    for (int k = 0; k < 8; k++) cyc(0, 16'h0, 1, 0, 0, 1);

    @(posedge clk); @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
